// File: rtl/stepper_multi_axis.sv
// stepper_multi_axis: NUM_AXES step/dir generators behind one Avalon-MM slave, {axis, reg[1:0]} addressing.
// Define STEPPER_LIMIT_EN to add synchronised per-axis limit inputs that abort moves and flag LIMIT_HIT.
module stepper_multi_axis #(
    parameter int NUM_AXES         = 4,
    parameter int DIR_SETUP_CYCLES = 50,
    parameter int DEFAULT_HALF     = 2,
    parameter int ADDR_W           = $clog2(NUM_AXES) + 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [ADDR_W-1:0]   address,
    input  logic                write,
    input  logic [31:0]         writedata,
    input  logic                read,
    output logic [31:0]         readdata,
    output logic [NUM_AXES-1:0] step,
    output logic [NUM_AXES-1:0] dir,
    output logic [NUM_AXES-1:0] busy,
    input  logic [NUM_AXES-1:0] limit
);
    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_HIGH, S_LOW} state_t;

    localparam logic [31:0] SETUP_M1 = 32'(DIR_SETUP_CYCLES - 1);

    logic [31:0] axis_idx;
    logic [1:0]  reg_sel;
    logic [31:0] rd_val [NUM_AXES];
    logic [31:0] rd_sel, readdata_d, readdata_q;

    assign axis_idx = 32'(address >> 2);
    assign reg_sel  = address[1:0];

`ifndef STEPPER_LIMIT_EN
    logic unused_limit;
    assign unused_limit = ^limit;
`endif

    for (genvar i = 0; i < NUM_AXES; i++) begin : g_axis
        state_t      state_q, state_d;
        logic [31:0] remain_q, remain_d, pos_q, pos_d, half_q, half_d, cnt_q, cnt_d;
        logic        dir_q, dir_d, abort_q, abort_d, reject_q, reject_d, lhit_q, lhit_d;
        logic        step_q, step_d, busy_q, busy_d;
        logic        sel, wr_move, wr_pos, wr_half, wr_ctrl, lim, do_abort, go_high;

        assign sel      = write && (axis_idx == i);
        assign wr_move  = sel && (reg_sel == 2'd0);
        assign wr_pos   = sel && (reg_sel == 2'd1);
        assign wr_half  = sel && (reg_sel == 2'd2);
        assign wr_ctrl  = sel && (reg_sel == 2'd3);

`ifdef STEPPER_LIMIT_EN
        logic [1:0] lsync_q, lsync_d;
        assign lsync_d = {lsync_q[0], limit[i]};
        always_ff @(posedge clk or negedge reset_n)
            if (!reset_n) lsync_q <= 2'b00;
            else          lsync_q <= lsync_d;
        assign lim = lsync_q[1];
`else
        assign lim = 1'b0;
`endif

        assign do_abort = (wr_ctrl && writedata[0]) || (lim && busy_q);

        always_comb begin
            state_d  = state_q;
            dir_d    = dir_q;
            remain_d = remain_q;
            pos_d    = pos_q;
            half_d   = wr_half ? ((writedata == 32'd0) ? 32'd1 : writedata) : half_q;
            cnt_d    = cnt_q;
            abort_d  = abort_q;
            reject_d = reject_q;
            lhit_d   = lhit_q;
            go_high  = 1'b0;
            if (wr_ctrl && writedata[1]) begin
                reject_d = 1'b0;
                lhit_d   = 1'b0;
            end
            if (lim && busy_q) lhit_d = 1'b1;
            if (wr_move && (busy_q || lim)) reject_d = 1'b1;
            case (state_q)
                S_IDLE: begin
                    if (wr_pos) pos_d = writedata;
                    if (wr_move && writedata != 32'd0 && !lim) begin
                        state_d  = S_SETUP;
                        dir_d    = !writedata[31];
                        remain_d = writedata[31] ? -writedata : writedata;
                        cnt_d    = SETUP_M1;
                        abort_d  = 1'b0;
                    end
                end
                S_SETUP: begin
                    if (do_abort) begin
                        state_d  = S_IDLE;
                        remain_d = 32'd0;
                    end else if (cnt_q == 32'd0) go_high = 1'b1;
                    else cnt_d = cnt_q - 32'd1;
                end
                S_HIGH: begin
                    if (do_abort) begin
                        abort_d  = 1'b1;
                        remain_d = 32'd0;
                    end
                    if (cnt_q == 32'd0) begin
                        state_d = (abort_q || do_abort) ? S_IDLE : S_LOW;
                        abort_d = 1'b0;
                        cnt_d   = half_q - 32'd1;
                    end else cnt_d = cnt_q - 32'd1;
                end
                S_LOW: begin
                    if (do_abort) begin
                        state_d  = S_IDLE;
                        remain_d = 32'd0;
                    end else if (cnt_q == 32'd0) begin
                        if (remain_q == 32'd0) state_d = S_IDLE;
                        else go_high = 1'b1;
                    end else cnt_d = cnt_q - 32'd1;
                end
                default: state_d = S_IDLE;
            endcase
            // Position and remaining count move on the rising edge of each step pulse
            if (go_high) begin
                state_d  = S_HIGH;
                pos_d    = dir_q ? pos_q + 32'd1 : pos_q - 32'd1;
                remain_d = remain_q - 32'd1;
                cnt_d    = half_q - 32'd1;
            end
            step_d = (state_d == S_HIGH);
            busy_d = (state_d != S_IDLE);
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                state_q  <= S_IDLE;
                dir_q    <= 1'b1;
                remain_q <= 32'd0;
                pos_q    <= 32'd0;
                half_q   <= 32'(DEFAULT_HALF);
                cnt_q    <= 32'd0;
                abort_q  <= 1'b0;
                reject_q <= 1'b0;
                lhit_q   <= 1'b0;
                step_q   <= 1'b0;
                busy_q   <= 1'b0;
            end else begin
                state_q  <= state_d;
                dir_q    <= dir_d;
                remain_q <= remain_d;
                pos_q    <= pos_d;
                half_q   <= half_d;
                cnt_q    <= cnt_d;
                abort_q  <= abort_d;
                reject_q <= reject_d;
                lhit_q   <= lhit_d;
                step_q   <= step_d;
                busy_q   <= busy_d;
            end
        end

        assign step[i]   = step_q;
        assign dir[i]    = dir_q;
        assign busy[i]   = busy_q;
        assign rd_val[i] = (reg_sel == 2'd0) ? remain_q :
                           (reg_sel == 2'd1) ? pos_q :
                           (reg_sel == 2'd2) ? half_q :
                           {28'd0, lhit_q, reject_q, dir_q, busy_q};
    end

    always_comb begin
        rd_sel = 32'd0;
        for (int k = 0; k < NUM_AXES; k++)
            if (axis_idx == k) rd_sel = rd_val[k];
        readdata_d = read ? rd_sel : readdata_q;
    end

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) readdata_q <= 32'd0;
        else          readdata_q <= readdata_d;

    assign readdata = readdata_q;
endmodule

// File: tb/tb_stepper_multi_axis.sv
// tb_stepper_multi_axis: directed register vectors plus hand sequences for move timing, reject, abort, wrap and reset.
module tb_stepper_multi_axis;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  address = '0;
    logic        write = 1'b0;
    logic [31:0] writedata = '0;
    logic        read = 1'b0;
    logic [31:0] readdata;
    logic [3:0]  step, dir, busy;
    logic [3:0]  limit = '0;

    int checks = 0;
    int errors = 0;

    stepper_multi_axis dut (
        .clk(clk), .reset_n(reset_n), .address(address), .write(write), .writedata(writedata),
        .read(read), .readdata(readdata), .step(step), .dir(dir), .busy(busy), .limit(limit)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          wr;
        logic [3:0]  addr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    vec_t vt [19];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    // All bus tasks start and end at a falling edge
    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        address = a; writedata = d; write = 1'b1;
        @(negedge clk);
        write = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] d);
        address = a; read = 1'b1;
        @(negedge clk);
        read = 1'b0;
        d = readdata;
    endtask

    task automatic run_pulses(input int ax, input int maxc, output int rises, output int highs, output int cyc);
        logic prev;
        prev = 1'b0; rises = 0; highs = 0; cyc = 0;
        while (busy[ax] && cyc < maxc) begin
            if (step[ax] && !prev) rises++;
            if (step[ax]) highs++;
            prev = step[ax];
            cyc++;
            @(negedge clk);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        int k, rises, highs, cyc, seen;
        logic prev;
        vt = '{
            '{1'b0, 4'h3, 32'h0, 32'h2},
            '{1'b0, 4'h2, 32'h0, 32'h2},
            '{1'b0, 4'h1, 32'h0, 32'h0},
            '{1'b0, 4'h0, 32'h0, 32'h0},
            '{1'b1, 4'hA, 32'h0, 32'h0},
            '{1'b0, 4'hA, 32'h0, 32'h1},
            '{1'b1, 4'hA, 32'h7, 32'h0},
            '{1'b0, 4'hA, 32'h0, 32'h7},
            '{1'b1, 4'hA, 32'h2, 32'h0},
            '{1'b1, 4'h9, 32'h1234, 32'h0},
            '{1'b0, 4'h9, 32'h0, 32'h1234},
            '{1'b1, 4'hD, 32'hFFFF_FFF9, 32'h0},
            '{1'b0, 4'hD, 32'h0, 32'hFFFF_FFF9},
            '{1'b1, 4'hD, 32'h0, 32'h0},
            '{1'b1, 4'h7, 32'h1, 32'h0},
            '{1'b0, 4'h7, 32'h0, 32'h2},
            '{1'b1, 4'h8, 32'h0, 32'h0},
            '{1'b0, 4'hB, 32'h0, 32'h2},
            '{1'b0, 4'h8, 32'h0, 32'h0}
        };

        repeat (3) @(negedge clk);
        check("rst_step", 32'(step), 32'h0);
        check("rst_dir", 32'(dir), 32'hF);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_readdata", readdata, 32'h0);
        reset_n = 1'b1;
        @(negedge clk);

        for (int n = 0; n < 19; n++) begin
            if (vt[n].wr) wr(vt[n].addr, vt[n].data);
            else begin
                rd(vt[n].addr, d);
                check($sformatf("vec%0d", n), d, vt[n].exp);
            end
        end

        // Axis2 MOVE=0 above must never start a move
        seen = 0;
        for (int c = 0; c < 60; c++) begin
            if (busy[2] || step[2]) seen++;
            @(negedge clk);
        end
        check("ax2_zero_move_idle", 32'(seen), 32'd0);

        // Axis0: +3 steps at HALF=2
        wr(4'h0, 32'd3);
        check("ax0_busy", 32'(busy[0]), 32'd1);
        check("ax0_dir", 32'(dir[0]), 32'd1);
        k = 0;
        while (!step[0] && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("ax0_setup_cycles", 32'(k), 32'd50);
        run_pulses(0, 100, rises, highs, cyc);
        check("ax0_rises", 32'(rises), 32'd3);
        check("ax0_highs", 32'(highs), 32'd6);
        check("ax0_busy_cycles", 32'(cyc), 32'd12);
        rd(4'h1, d); check("ax0_pos", d, 32'd3);
        rd(4'h0, d); check("ax0_remain", d, 32'd0);
        rd(4'h3, d); check("ax0_ctrl", d, 32'h2);

        // Axis1: -5, rejected +1 and ignored preset while busy
        wr(4'h4, 32'hFFFF_FFFB);
        check("ax1_dir", 32'(dir[1]), 32'd0);
        check("ax1_busy", 32'(busy[1]), 32'd1);
        wr(4'h4, 32'd1);
        wr(4'h5, 32'd99);
        rd(4'h7, d); check("ax1_ctrl_busy", d, 32'h5);
        run_pulses(1, 300, rises, highs, cyc);
        check("ax1_done_in_time", 32'(cyc < 300), 32'd1);
        check("ax1_rises", 32'(rises), 32'd5);
        check("ax1_highs", 32'(highs), 32'd10);
        rd(4'h5, d); check("ax1_pos", d, 32'hFFFF_FFFB);
        rd(4'h7, d); check("ax1_ctrl_reject", d, 32'h4);
        wr(4'h7, 32'h2);
        rd(4'h7, d); check("ax1_ctrl_cleared", d, 32'h0);

        // Axis3: +100, abort on the first cycle of the 10th high phase
        wr(4'hC, 32'd100);
        rises = 0; cyc = 0; prev = 1'b0;
        while (rises < 10 && cyc < 1000) begin
            @(negedge clk);
            if (step[3] && !prev) rises++;
            prev = step[3];
            cyc++;
        end
        check("ax3_ten_rises", 32'(rises), 32'd10);
        wr(4'hF, 32'h1);
        check("ax3_high_completes", 32'(step[3]), 32'd1);
        @(negedge clk);
        check("ax3_step_after_abort", 32'(step[3]), 32'd0);
        check("ax3_busy_after_abort", 32'(busy[3]), 32'd0);
        rd(4'hD, d); check("ax3_pos", d, 32'd10);
        rd(4'hC, d); check("ax3_remain", d, 32'd0);

        // Axis0: position wrap, then reset mid-move
        wr(4'h1, 32'h7FFF_FFFF);
        wr(4'h0, 32'd1);
        run_pulses(0, 200, rises, highs, cyc);
        check("wrap_rises", 32'(rises), 32'd1);
        rd(4'h1, d); check("wrap_pos", d, 32'h8000_0000);
        wr(4'h0, 32'd5);
        k = 0;
        while (!step[0] && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("rst_mid_step_seen", 32'(step[0]), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("rst_mid_step", 32'(step), 32'h0);
        check("rst_mid_busy", 32'(busy), 32'h0);
        check("rst_mid_dir", 32'(dir), 32'hF);
        check("rst_mid_readdata", readdata, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        rd(4'h1, d); check("rst_mid_pos", d, 32'h0);
        rd(4'h2, d); check("rst_mid_half", d, 32'h2);
        rd(4'h0, d); check("rst_mid_remain", d, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
